branch_resolution_queue: RTL and testbench

In-order tracking queue sitting between fetch and the global branch predictor. Fetch pushes each predicted conditional branch (PC plus predicted direction). Execute resolves the oldest entry with the actual outcome. The block then produces the registered training strobe for the predictor (predictor load, actual outcome, branch PC) and a one-cycle mispredict pulse that the pipeline uses to redirect and flush.

---
 rtl/branch_resolution_queue.sv | 108 ++++++++++
 tb/tb_branch_resolution_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted conditional branches awaiting resolution.
// Emits a registered predictor-training strobe and a one-cycle mispredict pulse.
module branch_resolution_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic                     enq_pred,
    output logic                     enq_ready,
    input  logic                     res_valid,
    input  logic                     res_br_en,
    input  logic                     flush,
    output logic                     upd_ld,
    output logic                     upd_br_en,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              mispred_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic             pred_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_ld_q, upd_ld_d, upd_br_q, upd_br_d, mis_q, mis_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic [15:0]      mispred_cnt_q, mispred_cnt_d;

    logic res_acc, mis_next, enq_acc;

    // Ready looks only at occupancy: a same-cycle resolve never frees a slot for enqueue.
    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign res_acc   = res_valid & (count_q != '0) & ~flush;
    assign mis_next  = res_acc & (res_br_en != pred_mem[head_q]);
    assign enq_acc   = enq_valid & enq_ready & ~flush & ~mis_next;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_ld_d      = res_acc;
        upd_br_d      = upd_br_q;
        upd_pc_d      = upd_pc_q;
        mis_d         = mis_next;
        mispred_cnt_d = mispred_cnt_q;

        if (res_acc) begin
            upd_br_d = res_br_en;
            upd_pc_d = pc_mem[head_q];
        end

        // Mispredict squashes every younger entry along with any same-cycle enqueue.
        if (flush || mis_next) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (res_acc) head_d = head_q + 1'b1;
            if (enq_acc) tail_d = tail_q + 1'b1;
            count_d = count_q + CNT_W'(enq_acc) - CNT_W'(res_acc);
        end

        if (mis_next && mispred_cnt_q != 16'hFFFF)
            mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_ld_q      <= 1'b0;
            upd_br_q      <= 1'b0;
            upd_pc_q      <= '0;
            mis_q         <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_ld_q      <= upd_ld_d;
            upd_br_q      <= upd_br_d;
            upd_pc_q      <= upd_pc_d;
            mis_q         <= mis_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry storage is left unreset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (enq_acc) begin
            pc_mem[tail_q]   <= enq_pc;
            pred_mem[tail_q] <= enq_pred;
        end
    end

    assign upd_ld        = upd_ld_q;
    assign upd_br_en     = upd_br_q;
    assign upd_pc        = upd_pc_q;
    assign mispredict    = mis_q;
    assign count         = count_q;
    assign mispred_count = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolution_queue.sv
// Scoreboard bench for branch_resolution_queue: a reference queue model predicts
// every training strobe, pushed when a resolve is driven and popped on upd_ld.
module tb_branch_resolution_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct { logic [PC_W-1:0] pc; logic pred; }        ent_t;
    typedef struct { logic [PC_W-1:0] pc; logic br; logic mis; } upd_t;

    logic            clk, rst;
    logic            enq_valid, enq_pred, enq_ready;
    logic [PC_W-1:0] enq_pc;
    logic            res_valid, res_br_en, flush;
    logic            upd_ld, upd_br_en, mispredict;
    logic [PC_W-1:0] upd_pc;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]     mispred_count;

    branch_resolution_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_ready(enq_ready),
        .res_valid(res_valid), .res_br_en(res_br_en), .flush(flush),
        .upd_ld(upd_ld), .upd_br_en(upd_br_en), .upd_pc(upd_pc),
        .mispredict(mispredict), .count(count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_chk = 0, n_err = 0;
    ent_t      mq[$];
    upd_t      sb[$];
    logic [15:0]     mcnt = '0;
    logic [PC_W-1:0] last_pc = '0;
    logic            last_br = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, update the model, compare #1 after the posedge.
    task automatic step(input logic ev, input logic [PC_W-1:0] pc, input logic pr,
                        input logic rv, input logic br, input logic fl);
        logic racc, mis, eacc;
        upd_t u;
        @(negedge clk);
        enq_valid = ev; enq_pc = pc; enq_pred = pr;
        res_valid = rv; res_br_en = br; flush = fl;
        #1 chk("enq_ready", enq_ready, mq.size() < DEPTH);
        racc = rv && mq.size() != 0 && !fl;
        mis  = racc && (br != mq[0].pred);
        eacc = ev && mq.size() < DEPTH && !fl && !mis;
        if (racc) begin
            sb.push_back('{pc: mq[0].pc, br: br, mis: mis});
            mq.delete(0);
        end
        if (fl || mis) mq.delete();
        else if (eacc) mq.push_back('{pc: pc, pred: pr});
        if (mis && mcnt != 16'hFFFF) mcnt++;
        @(posedge clk);
        #1;
        chk("upd_ld", upd_ld, racc);
        if (upd_ld) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                u = sb.pop_front();
                last_pc = u.pc;
                last_br = u.br;
                chk("mispredict", mispredict, u.mis);
            end
        end else chk("mispredict_idle", mispredict, 0);
        chk("upd_pc", upd_pc, last_pc);
        chk("upd_br_en", upd_br_en, last_br);
        chk("count", count, mq.size());
        chk("mispred_count", mispred_count, mcnt);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, 0);
    endtask

    function automatic logic front_pred();
        return (mq.size() != 0) ? mq[0].pred : 1'b0;
    endfunction

    initial begin
        rst = 1'b0; enq_valid = 0; enq_pc = '0; enq_pred = 0;
        res_valid = 0; res_br_en = 0; flush = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_upd_ld", upd_ld, 0);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_mcnt", mispred_count, 0);
        @(negedge clk) rst = 1'b1;

        // In-order training, all correctly predicted
        step(1, 32'h100, 1, 0, 0, 0);
        step(1, 32'h104, 0, 0, 0, 0);
        step(1, 32'h108, 1, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        idle();

        // Mispredict squashes younger entries and the same-cycle enqueue
        step(1, 32'h200, 1, 0, 0, 0);
        step(1, 32'h204, 0, 0, 0, 0);
        step(1, 32'h208, 1, 0, 0, 0);
        step(1, 32'h20C, 1, 1, 0, 0);
        idle();

        // Full queue: no enqueue even alongside a resolve
        step(1, 32'h310, 1, 0, 0, 0);
        step(1, 32'h314, 0, 0, 0, 0);
        step(1, 32'h318, 0, 0, 0, 0);
        step(1, 32'h31C, 1, 0, 0, 0);
        step(1, 32'h300, 0, 0, 0, 0);
        step(1, 32'h300, 0, 1, front_pred(), 0);

        // Overlapped enqueue/resolve across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            if (i % 4 == 3) step(0, '0, 0, 1, front_pred(), 0);
            else            step(1, 32'h400 + 32'(4 * i), i[0], 1, front_pred(), 0);
        end
        while (mq.size() != 0) step(0, '0, 0, 1, front_pred(), 0);

        // Flush beats a same-cycle mispredicting resolve and enqueue
        step(1, 32'h500, 1, 0, 0, 0);
        step(1, 32'h504, 0, 0, 0, 0);
        step(1, 32'h508, 1, 0, 0, 0);
        step(1, 32'h50C, 1, 1, ~front_pred(), 1);
        idle();

        // Resolve on empty is ignored
        step(0, '0, 0, 1, 1, 0);

        // Saturation of the mispredict counter
        @(negedge clk) force dut.mispred_cnt_q = 16'hFFFE;
        mcnt = 16'hFFFE;
        idle();
        @(negedge clk) release dut.mispred_cnt_q;
        idle();
        step(1, 32'h600, 1, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        step(1, 32'h604, 0, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        idle();

        // Asynchronous reset mid-stream, right after a training pulse
        step(1, 32'h700, 1, 0, 0, 0);
        step(1, 32'h704, 1, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        rst = 1'b0;
        #1;
        chk("arst_upd_ld", upd_ld, 0);
        chk("arst_upd_pc", upd_pc, 0);
        chk("arst_upd_br_en", upd_br_en, 0);
        chk("arst_mispredict", mispredict, 0);
        chk("arst_count", count, 0);
        chk("arst_enq_ready", enq_ready, 1);
        chk("arst_mcnt", mispred_count, 0);
        mq.delete(); sb.delete();
        mcnt = '0; last_pc = '0; last_br = 1'b0;
        @(negedge clk) rst = 1'b1;
        step(0, '0, 0, 1, 1, 0);
        step(1, 32'h800, 0, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
